// File: rtl/move_executor_pkg.sv
// Shared definitions for the move executor: FSM encoding, direction codes
// and the layout of the speed word.
package move_executor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_BRAKE = 3'd4
    } state_t;

    localparam logic [1:0] DIR_FWD   = 2'd0;
    localparam logic [1:0] DIR_REV   = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Duty sits in the low bits of the speed word; duration follows it.
    localparam int DUTY_LSB = 0;

    function automatic int dur_lsb(input int pwm_w);
        return DUTY_LSB + pwm_w;
    endfunction

    // Returns {left_dir, right_dir}, 1 = forward.
    function automatic logic [1:0] dir_decode(input logic [1:0] code);
        logic [1:0] lr;
        case (code)
            DIR_FWD:   lr = 2'b11;
            DIR_REV:   lr = 2'b00;
            DIR_LEFT:  lr = 2'b01;
            default:   lr = 2'b10;
        endcase
        return lr;
    endfunction

endpackage

// File: rtl/move_executor_pwm_gen.sv
// Free-running PWM counter with compare. Counter advances only while en is
// high; output is registered and forced low whenever en is low.
module pwm_gen #(
    parameter int W = 8
) (
    input  logic         clck,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] duty,
    output logic         pwm
);

    logic [W-1:0] cnt;

    always_ff @(posedge clck or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else if (en) begin
            cnt <= cnt + W'(1);
            pwm <= (cnt < duty);
        end else begin
            pwm <= 1'b0;
        end
    end

endmodule

// File: rtl/move_executor.sv
// Executes the head entry of the move queue: drives both motors for the
// move's duration, pulses shift, then brakes before accepting the next move.
module move_executor
    import move_executor_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 1000,
    parameter int BRAKE_CYC = 64
) (
    input  logic        clck,
    input  logic        reset,
    input  logic        enable,
    input  logic        move_valid,
    input  logic [31:0] dir_in,
    input  logic [31:0] speed_in,
    output logic        shift,
    output logic        busy,
    output logic        motor_l_pwm,
    output logic        motor_r_pwm,
    output logic        motor_l_dir,
    output logic        motor_r_dir,
    output logic [15:0] moves_done
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BRK_W   = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
    localparam int DUR_LSB = dur_lsb(PWM_W);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BRK_W-1:0]  BRK_LAST  = BRK_W'((BRAKE_CYC > 0) ? BRAKE_CYC - 1 : 0);

    state_t             state, state_nx;
    logic [PWM_W-1:0]   duty_q;
    logic [DUR_W-1:0]   dur_q;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BRK_W-1:0]   brake_cnt;
    logic [1:0]         pwm_bits;

    logic [DUR_W-1:0]   dur_in;
    logic [PWM_W-1:0]   duty_in;
    logic               run_act;
    logic               last_tick;
    logic               unused_dir;

    assign dur_in    = speed_in[DUR_LSB +: DUR_W];
    assign duty_in   = speed_in[DUTY_LSB +: PWM_W];
    assign run_act   = (state == ST_RUN) && enable;
    assign last_tick = (tick_cnt == TICK_LAST);
    assign unused_dir = ^dir_in[31:2];

    generate
        if (PWM_W + DUR_W < 32) begin : g_unused
            logic unused_speed;
            assign unused_speed = ^speed_in[31:PWM_W+DUR_W];
        end
    endgenerate

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (enable && move_valid) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = (dur_in == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (run_act && last_tick && dur_q == DUR_W'(1)) state_nx = ST_DONE;
            ST_DONE:  state_nx = (BRAKE_CYC > 0) ? ST_BRAKE : ST_IDLE;
            ST_BRAKE: if (brake_cnt == BRK_LAST) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clck or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            duty_q      <= '0;
            dur_q       <= '0;
            tick_cnt    <= '0;
            brake_cnt   <= '0;
            shift       <= 1'b0;
            busy        <= 1'b0;
            motor_l_dir <= 1'b0;
            motor_r_dir <= 1'b0;
            moves_done  <= '0;
        end else begin
            state <= state_nx;
            // Status outputs are registered from the next state so they line
            // up with the cycle the FSM actually occupies.
            shift <= (state_nx == ST_DONE);
            busy  <= (state_nx != ST_IDLE);
            if (state_nx == ST_DONE)
                moves_done <= moves_done + 16'd1;

            case (state)
                ST_LOAD: begin
                    duty_q   <= duty_in;
                    dur_q    <= dur_in;
                    tick_cnt <= '0;
                    {motor_l_dir, motor_r_dir} <= dir_decode(dir_in[1:0]);
                end
                ST_RUN: begin
                    if (run_act) begin
                        if (last_tick) begin
                            tick_cnt <= '0;
                            dur_q    <= dur_q - DUR_W'(1);
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                ST_DONE:  brake_cnt <= '0;
                ST_BRAKE: brake_cnt <= brake_cnt + BRK_W'(1);
                default:  ;
            endcase
        end
    end

    // One generator per motor; both see the same duty and phase.
    generate
        for (genvar m = 0; m < 2; m++) begin : g_motor
            pwm_gen #(.W(PWM_W)) u_pwm (
                .clck  (clck),
                .reset (reset),
                .clr   (state == ST_LOAD),
                .en    (run_act),
                .duty  (duty_q),
                .pwm   (pwm_bits[m])
            );
        end
    endgenerate

    assign motor_l_pwm = pwm_bits[1];
    assign motor_r_pwm = pwm_bits[0];

endmodule

// File: tb/tb_move_executor.sv
// Directed bench for move_executor with PWM_W=3, TICK_DIV=4, BRAKE_CYC=2.
module tb_move_executor;

    localparam int BRAKE = 2;

    logic        clck = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        move_valid = 1'b0;
    logic [31:0] dir_in = '0;
    logic [31:0] speed_in = '0;
    logic        shift, busy, motor_l_pwm, motor_r_pwm, motor_l_dir, motor_r_dir;
    logic [15:0] moves_done;

    always #5 clck = ~clck;

    move_executor #(.PWM_W(3), .DUR_W(16), .TICK_DIV(4), .BRAKE_CYC(BRAKE)) dut (
        .clck(clck), .reset(reset), .enable(enable), .move_valid(move_valid),
        .dir_in(dir_in), .speed_in(speed_in), .shift(shift), .busy(busy),
        .motor_l_pwm(motor_l_pwm), .motor_r_pwm(motor_r_pwm),
        .motor_l_dir(motor_l_dir), .motor_r_dir(motor_r_dir), .moves_done(moves_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  dir;
        logic [2:0]  duty;
        logic [15:0] dur;
    } mv_t;

    mv_t        q[$];
    logic [1:0] dir_at_shift[$];
    int         shift_cyc[$];
    int cyc = 0, shifts = 0, hi_l = 0, hi_r = 0, last_shift = 0;
    int since_shift = 1000, brake_viol = 0, pause_viol = 0;
    logic en_s = 1'b0;

    always @(posedge clck) en_s <= enable;

    // Queue model and output monitor: pops the head on each shift pulse.
    initial forever begin
        @(negedge clck);
        cyc++;
        since_shift++;
        if (motor_l_pwm) hi_l++;
        if (motor_r_pwm) hi_r++;
        if (!en_s && (motor_l_pwm || motor_r_pwm)) pause_viol++;
        if (since_shift >= 1 && since_shift <= BRAKE && (motor_l_pwm || motor_r_pwm)) brake_viol++;
        if (shift) begin
            shifts++;
            last_shift = cyc;
            since_shift = 0;
            shift_cyc.push_back(cyc);
            dir_at_shift.push_back({motor_l_dir, motor_r_dir});
            if (q.size() > 0) q.delete(0);
        end
        move_valid = (q.size() > 0);
        if (q.size() > 0) begin
            dir_in   = {30'h2aaaaaaa, q[0].dir};
            speed_in = {13'h1555, q[0].dur, q[0].duty};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int c0, s0, l0, r0;

    task automatic start();
        @(posedge clck);
        c0 = cyc; s0 = shifts; l0 = hi_l; r0 = hi_r;
    endtask

    task automatic wait_idle(input int target);
        int t;
        t = 0;
        while (shifts < target && t < 400) begin
            @(posedge clck);
            t++;
        end
        t = 0;
        while (busy && t < 50) begin
            @(posedge clck);
            t++;
        end
        repeat (4) @(posedge clck);
        #1;
        chk("shift_cnt", shifts, target);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clck);
        #1;
        chk("rst_outs", {shift, busy, motor_l_pwm, motor_r_pwm, motor_l_dir, motor_r_dir, moves_done}, 0);
        @(negedge clck);
        reset = 1'b1;
        enable = 1'b1;
        repeat (2) @(posedge clck);
        #1;
        chk("post_rst_busy", busy, 0);

        // basic forward move
        start();
        q.push_back('{dir: 2'd0, duty: 3'd3, dur: 16'd4});
        wait_idle(s0 + 1);
        chk("basic_lat", last_shift - c0, 19);
        chk("basic_hi_l", hi_l - l0, 6);
        chk("basic_hi_r", hi_r - r0, 6);
        chk("basic_dir", dir_at_shift[$], 2'b11);
        chk("basic_done", moves_done, 1);

        // turn right then reverse, queued together
        start();
        q.push_back('{dir: 2'd3, duty: 3'd5, dur: 16'd2});
        q.push_back('{dir: 2'd1, duty: 3'd2, dur: 16'd1});
        wait_idle(s0 + 2);
        chk("b2b_dir_right", dir_at_shift[$-1], 2'b10);
        chk("b2b_dir_rev", dir_at_shift[$], 2'b00);
        chk("b2b_gap", shift_cyc[$] - shift_cyc[$-1], 9);
        chk("b2b_hi_l", hi_l - l0, 7);
        chk("b2b_hi_r", hi_r - r0, 7);
        chk("brake_pwm", brake_viol, 0);
        chk("b2b_done", moves_done, 3);

        // zero duration turn left
        start();
        q.push_back('{dir: 2'd2, duty: 3'd5, dur: 16'd0});
        wait_idle(s0 + 1);
        chk("zero_lat", last_shift - c0, 3);
        chk("zero_hi", (hi_l - l0) + (hi_r - r0), 0);
        chk("zero_dir", dir_at_shift[$], 2'b01);
        chk("zero_done", moves_done, 4);

        // pause for 10 cycles mid-RUN
        start();
        q.push_back('{dir: 2'd0, duty: 3'd3, dur: 16'd4});
        wait (cyc == c0 + 8);
        enable = 1'b0;
        wait (cyc == c0 + 18);
        enable = 1'b1;
        wait_idle(s0 + 1);
        chk("pause_lat", last_shift - c0, 29);
        chk("pause_hi_l", hi_l - l0, 6);
        chk("pause_pwm", pause_viol, 0);
        chk("pause_done", moves_done, 5);

        // duty extremes
        start();
        q.push_back('{dir: 2'd0, duty: 3'd0, dur: 16'd2});
        wait_idle(s0 + 1);
        chk("duty0_hi", (hi_l - l0) + (hi_r - r0), 0);
        start();
        q.push_back('{dir: 2'd0, duty: 3'd7, dur: 16'd2});
        wait_idle(s0 + 1);
        chk("duty7_hi_l", hi_l - l0, 7);
        chk("duty7_hi_r", hi_r - r0, 7);
        chk("duty_done", moves_done, 7);

        // reset in the middle of RUN
        start();
        q.push_back('{dir: 2'd0, duty: 3'd3, dur: 16'd4});
        wait (cyc == c0 + 7);
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", {shift, busy, motor_l_pwm, motor_r_pwm, motor_l_dir, motor_r_dir, moves_done}, 0);
        repeat (3) @(posedge clck);
        #1;
        chk("rst_mid_q", q.size(), 1);
        @(negedge clck);
        reset = 1'b1;
        l0 = hi_l;
        wait_idle(s0 + 1);
        chk("rerun_hi_l", hi_l - l0, 6);
        chk("rerun_done", moves_done, 1);
        chk("rerun_q", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/move_executor.md
Name: move_executor

Overview:
- Consumes the head entry of the movement queue: one direction word and one speed word per move.
- Drives the left/right motor PWM and direction lines for that move's duration, then pulses `shift` so the queue advances to the next entry.
- Sits directly downstream of the move queue and directly upstream of the motor driver pins.

Parameters:
- PWM_W, 8, PWM counter width; PWM period = 2^PWM_W clock cycles.
- DUR_W, 16, duration field width, in ticks.
- TICK_DIV, 1000, clock cycles per duration tick (must be ≥1).
- BRAKE_CYC, 64, idle cycles with motors off between consecutive moves (0 allowed).

Ports:
- clck  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  execution enable; low pauses the current move.
- move_valid  in  1  queue head holds a pending move.
- dir_in  in  32  direction word of queue head; bits[1:0] used, bits[31:2] ignored.
- speed_in  in  32  bits[PWM_W-1:0] = duty; bits[PWM_W+DUR_W-1:PWM_W] = duration in ticks; upper bits ignored.
- shift  out  1  one-cycle pulse: current move finished, advance the queue.
- busy  out  1  high in every state except IDLE.
- motor_l_pwm  out  1  left motor PWM.
- motor_r_pwm  out  1  right motor PWM.
- motor_l_dir  out  1  left motor direction (1 = forward).
- motor_r_dir  out  1  right motor direction (1 = forward).
- moves_done  out  16  count of completed moves; wraps at 2^16.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All counters and latched fields cleared.
  - shift=0, busy=0, both pwm=0, both dir=0, moves_done=0.
  - Reset mid-move aborts the move with no shift pulse; the queue entry is retained.
- States: IDLE, LOAD, RUN, DONE, BRAKE. All outputs are driven from registers; no combinational path from inputs to outputs.
- IDLE:
  - enable=1 and move_valid=1 → LOAD next cycle.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - Latch dir_q=dir_in[1:0], duty_q, dur_q.
  - Clear pwm_cnt and tick_cnt.
  - dur_q==0 → DONE (zero-duration move is skipped); else → RUN.
  - dir_in/speed_in are sampled only in LOAD and may change afterwards.
- Direction decode (latched in LOAD, held until the next LOAD):
  - 0 = forward: l=1, r=1.
  - 1 = reverse: l=0, r=0.
  - 2 = turn left: l=0, r=1.
  - 3 = turn right: l=1, r=0.
- RUN:
  - pwm_cnt increments every active cycle and wraps at 2^PWM_W.
  - Both pwm outputs = (pwm_cnt < duty_q) during active cycles.
  - duty_q==0 → pwm never high.
  - tick_cnt counts to TICK_DIV-1 then wraps; each wrap decrements dur_q.
  - When dur_q reaches 0 → DONE.
  - RUN lasts exactly dur×TICK_DIV active cycles.
- Pause: enable=0 in RUN:
  - Both pwm forced 0.
  - pwm_cnt, tick_cnt and dur_q hold.
  - Resumes in the same phase when enable returns to 1.
  - Paused cycles do not count toward the duration.
- DONE (exactly 1 cycle):
  - shift=1 and moves_done+1.
  - BRAKE_CYC>0 → BRAKE; else → IDLE.
- BRAKE:
  - pwm=0, dir held.
  - After BRAKE_CYC cycles → IDLE.
  - enable is ignored in BRAKE.
- Latency: move_valid=1 sampled in IDLE at edge N → LOAD during cycle N+1 → first RUN cycle N+2.
- Back-to-back moves with BRAKE_CYC=0: DONE → IDLE → LOAD, so 3 non-RUN cycles separate consecutive moves.
- Boundary cases:
  - move_valid dropping while busy has no effect.
  - Maximum duty 2^PWM_W-1 gives a high time of (2^PWM_W-1)/2^PWM_W.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=0, LOAD=1, RUN=2, DONE=3, BRAKE=4).
  - Direction codes DIR_FWD/DIR_REV/DIR_LEFT/DIR_RIGHT.
  - Speed-word field offsets.
- One sub-module: `pwm_gen` (counter plus compare, with enable/hold and clear inputs).
- FSM, tick and duration counters stay in `move_executor`.

Test Plan (PWM_W=3, TICK_DIV=4, BRAKE_CYC=2):
- Basic move: dir=0, duty=3, dur=4, move_valid held 1 → RUN for 16 cycles, 6 pwm-high cycles on each motor, l_dir=r_dir=1, exactly one shift pulse, moves_done=1.
- Turn right then reverse queued back-to-back:
  - Right: l_dir=1, r_dir=0.
  - Reverse: both dir=0.
  - Exactly two shift pulses.
  - 2 BRAKE cycles with pwm=0 between the moves.
- Zero duration: dur=0 → no RUN cycles, shift pulses 2 cycles after acceptance, pwm stays 0.
- Pause: enable dropped for 10 cycles mid-RUN (dur=4) → pwm=0 throughout the pause; total RUN active cycles still 16; shift delayed by exactly 10 cycles.
- Duty extremes:
  - duty=0 → pwm never high.
  - duty=7 → 7 of 8 cycles high per period.
- Reset mid-RUN: assert reset at RUN cycle 5 → all outputs 0 immediately, no shift, moves_done=0; after release the same entry executes in full.
